// File: rtl/boot_rom_copier_if.sv
// Bus bundle between the boot-image copier, the boot ROM and the core's
// download port. The copier is the master of both the ROM read address and
// the download write channel; the ROM/core side is the slave.
interface boot_rom_copier_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);

  // ROM read side
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  // Core download side
  logic              dn_go;
  logic              dn_wr;
  logic [ADDR_W-1:0] dn_addr;
  logic [DATA_W-1:0] dn_data;
  logic              dn_wait;

  modport master (
    output rom_addr,
    input  rom_data,
    output dn_go,
    output dn_wr,
    output dn_addr,
    output dn_data,
    input  dn_wait
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  dn_go,
    input  dn_wr,
    input  dn_addr,
    input  dn_data,
    output dn_wait
  );

endinterface

// File: rtl/boot_rom_copier.sv
// Boot-image copy engine. On a start request it reads LENGTH words from the
// boot ROM (addresses 0 upward), writes each one to the core download port at
// DEST_BASE + index, honouring target back-pressure, and finally pulses
// execute_enable together with the entry point EXEC_ADDR.
module boot_rom_copier #(
  parameter int              ADDR_W    = 16,
  parameter int              DATA_W    = 8,
  parameter int              LENGTH    = 276,
  parameter int              ROM_LAT   = 1,
  parameter logic [ADDR_W-1:0] DEST_BASE = {ADDR_W{1'b0}},
  parameter logic [ADDR_W-1:0] EXEC_ADDR = {ADDR_W{1'b0}}
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                start,
  boot_rom_copier_if.master   bus,
  output logic [ADDR_W-1:0]   execute_addr,
  output logic                execute_enable,
  output logic                done
);

  // Parameter legality, rejected at elaboration time.
  localparam longint unsigned ADDR_SPAN = 64'd1 << ADDR_W;

  if ((LENGTH < 32'sd1) || (64'(LENGTH) > ADDR_SPAN)) begin : g_bad_length
    $error("boot_rom_copier: LENGTH must be in 1..2**ADDR_W");
  end

  if ((ROM_LAT < 32'sd1) || (ROM_LAT > 32'sd4)) begin : g_bad_rom_lat
    $error("boot_rom_copier: ROM_LAT must be in 1..4");
  end

  // Index of the final word, and terminal value of the ROM latency counter.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(LENGTH - 1);
  localparam logic [2:0]      LAT_LAST = 3'(ROM_LAT - 1);
  localparam logic [ADDR_W:0] IDX_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2,
    S_EXEC  = 2'd3
  } state_t;

  state_t              state_q,     state_d;
  logic [ADDR_W:0]     index_q,     index_d;
  logic [2:0]          lat_cnt_q,   lat_cnt_d;
  logic [ADDR_W-1:0]   rom_addr_q,  rom_addr_d;
  logic                dn_go_q,     dn_go_d;
  logic                dn_wr_q,     dn_wr_d;
  logic [ADDR_W-1:0]   dn_addr_q,   dn_addr_d;
  logic [DATA_W-1:0]   dn_data_q,   dn_data_d;
  logic [ADDR_W-1:0]   exec_addr_q, exec_addr_d;
  logic                exec_en_q,   exec_en_d;
  logic                done_q,      done_d;
  logic [ADDR_W:0]     next_index;

  // Next-state and next-output computation for the copy sequencer.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    lat_cnt_d   = lat_cnt_q;
    rom_addr_d  = rom_addr_q;
    dn_go_d     = dn_go_q;
    dn_wr_d     = dn_wr_q;
    dn_addr_d   = dn_addr_q;
    dn_data_d   = dn_data_q;
    done_d      = done_q;
    exec_en_d   = 1'b0;
    exec_addr_d = {ADDR_W{1'b0}};
    next_index  = index_q + IDX_ONE;

    case (state_q)
      S_IDLE: begin
        // The cycle carrying the execute pulse is still the tail of the
        // previous copy, so a start seen there is dropped.
        if (start && !exec_en_q) begin
          state_d    = S_FETCH;
          index_d    = {(ADDR_W + 1){1'b0}};
          lat_cnt_d  = 3'd0;
          rom_addr_d = {ADDR_W{1'b0}};
          dn_go_d    = 1'b1;
          dn_wr_d    = 1'b0;
          done_d     = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FETCH: begin
        rom_addr_d = index_q[ADDR_W-1:0];
        if (lat_cnt_q == LAT_LAST) begin
          // ROM output has settled for the current address: launch the write.
          lat_cnt_d = 3'd0;
          dn_data_d = bus.rom_data;
          dn_addr_d = DEST_BASE + index_q[ADDR_W-1:0];
          dn_wr_d   = 1'b1;
          state_d   = S_WRITE;
        end else begin
          lat_cnt_d = lat_cnt_q + 3'd1;
          state_d   = S_FETCH;
        end
      end

      S_WRITE: begin
        if (!bus.dn_wait) begin
          dn_wr_d = 1'b0;
          if (index_q == LAST_IDX) begin
            state_d = S_EXEC;
          end else begin
            index_d    = next_index;
            rom_addr_d = next_index[ADDR_W-1:0];
            state_d    = S_FETCH;
          end
        end else begin
          // Target stalled: address, data and strobe stay as they are.
          state_d = S_WRITE;
        end
      end

      S_EXEC: begin
        dn_go_d     = 1'b0;
        exec_en_d   = 1'b1;
        exec_addr_d = EXEC_ADDR;
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        dn_go_d = 1'b0;
        dn_wr_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any copy without an execute pulse.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      index_q     <= {(ADDR_W + 1){1'b0}};
      lat_cnt_q   <= 3'd0;
      rom_addr_q  <= {ADDR_W{1'b0}};
      dn_go_q     <= 1'b0;
      dn_wr_q     <= 1'b0;
      dn_addr_q   <= {ADDR_W{1'b0}};
      dn_data_q   <= {DATA_W{1'b0}};
      exec_addr_q <= {ADDR_W{1'b0}};
      exec_en_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      lat_cnt_q   <= lat_cnt_d;
      rom_addr_q  <= rom_addr_d;
      dn_go_q     <= dn_go_d;
      dn_wr_q     <= dn_wr_d;
      dn_addr_q   <= dn_addr_d;
      dn_data_q   <= dn_data_d;
      exec_addr_q <= exec_addr_d;
      exec_en_q   <= exec_en_d;
      done_q      <= done_d;
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.dn_go       = dn_go_q;
  assign bus.dn_wr       = dn_wr_q;
  assign bus.dn_addr     = dn_addr_q;
  assign bus.dn_data     = dn_data_q;
  assign execute_addr    = exec_addr_q;
  assign execute_enable  = exec_en_q;
  assign done            = done_q;

endmodule

// File: tb/tb_boot_rom_copier.sv
// Self-checking bench for boot_rom_copier. Two instances: one with default
// parameters (ROM[i] = i[7:0]) and one with ROM_LAT=3, DEST_BASE=16'hFFFE,
// LENGTH=4, EXEC_ADDR=16'hBEEF (ROM[i] = i[7:0]^8'hA5). Expected writes are
// queued when a copy is started and popped as the DUT's writes are accepted.
module tb_boot_rom_copier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start0, start1;
  logic        wait0, wait1;
  logic [15:0] ea0, ea1;
  logic        ee0, ee1, done0, done1;
  logic [15:0] a1_p1, a1_p2;

  boot_rom_copier_if #(.ADDR_W(16), .DATA_W(8)) bus0 ();
  boot_rom_copier_if #(.ADDR_W(16), .DATA_W(8)) bus1 ();

  // ROM for instance 0: single-cycle latency, contents i[7:0].
  assign bus0.rom_data = bus0.rom_addr[7:0];
  assign bus0.dn_wait  = wait0;

  // ROM for instance 1: address passes two register stages (3-cycle latency).
  always @(posedge clk) begin
    a1_p1 <= bus1.rom_addr;
    a1_p2 <= a1_p1;
  end
  assign bus1.rom_data = a1_p2[7:0] ^ 8'hA5;
  assign bus1.dn_wait  = wait1;

  boot_rom_copier dut0 (
    .clk_sys(clk), .reset_n(reset_n), .start(start0), .bus(bus0),
    .execute_addr(ea0), .execute_enable(ee0), .done(done0)
  );

  boot_rom_copier #(
    .LENGTH(4), .ROM_LAT(3), .DEST_BASE(16'hFFFE), .EXEC_ADDR(16'hBEEF)
  ) dut1 (
    .clk_sys(clk), .reset_n(reset_n), .start(start1), .bus(bus1),
    .execute_addr(ea1), .execute_enable(ee1), .done(done1)
  );

  typedef struct {
    int          dut;
    logic [15:0] addr;
    logic [7:0]  data;
    int          rel;   // accepting edge, counted from the start edge
    int          run;   // cycles dn_wr is high for this word
  } wr_t;

  typedef struct {
    int          dut;
    int          sw;      // stalled word
    int          sl;      // stall cycles (0 = none)
    int          exp_cyc; // start edge to execute_enable rising
    int          exp_wr;
    logic [15:0] exp_ea;
  } vec_t;

  wr_t         sq[$];
  vec_t        vt[5];
  int          n_chk, n_fail, cyc;
  int          s_cyc[2], run[2], wr_cnt[2], ee_cnt[2], ee_rel[2];
  logic [15:0] pa[2], ee_addr[2];
  logic [7:0]  pd[2];
  logic        ee_done[2], ee_go[2];
  logic [15:0] stall_addr;
  int          stall_left;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic get_sigs(input int d, output logic go, output logic wr, output logic ee,
                          output logic dn, output logic [15:0] ea, output logic [15:0] ra,
                          output logic [15:0] ad, output logic [7:0] da);
    if (d == 0) begin
      go = bus0.dn_go; wr = bus0.dn_wr; ee = ee0; dn = done0;
      ea = ea0; ra = bus0.rom_addr; ad = bus0.dn_addr; da = bus0.dn_data;
    end else begin
      go = bus1.dn_go; wr = bus1.dn_wr; ee = ee1; dn = done1;
      ea = ea1; ra = bus1.rom_addr; ad = bus1.dn_addr; da = bus1.dn_data;
    end
  endtask

  task automatic drive_wait();
    if (bus0.dn_wr && (bus0.dn_addr == stall_addr) && (stall_left > 0)) begin
      wait0 = 1'b1;
      stall_left--;
    end else if (bus0.dn_wr) begin
      wait0 = 1'b0;
    end else begin
      wait0 = 1'($urandom_range(0, 1));
    end
    wait1 = 1'b0;
  endtask

  task automatic monitor(input int d);
    logic go, wr, ee, dn, wt;
    logic [15:0] ea, ra, ad;
    logic [7:0] da;
    wr_t e;
    get_sigs(d, go, wr, ee, dn, ea, ra, ad, da);
    wt = (d == 0) ? wait0 : wait1;
    if (wr) begin
      if (run[d] > 0) begin
        chk("hold_addr", 32'(ad), 32'(pa[d]));
        chk("hold_data", 32'(da), 32'(pd[d]));
      end
      run[d]++;
      pa[d] = ad;
      pd[d] = da;
      if (!wt) begin
        wr_cnt[d]++;
        chk("write_expected", 32'(sq.size() > 0), 32'd1);
        if (sq.size() > 0) begin
          e = sq.pop_front();
          chk("write_dut", d, e.dut);
          chk("write_addr", 32'(ad), 32'(e.addr));
          chk("write_data", 32'(da), 32'(e.data));
          chk("write_cycle", cyc + 1 - s_cyc[d], e.rel);
          chk("write_hold_cycles", run[d], e.run);
          chk("go_during_write", 32'(go), 32'd1);
        end
        run[d] = 0;
      end
    end else begin
      run[d] = 0;
    end
    if (ee) begin
      ee_cnt[d]++;
      ee_rel[d]  = cyc - s_cyc[d];
      ee_addr[d] = ea;
      ee_done[d] = dn;
      ee_go[d]   = go;
    end
  endtask

  // One clock: wait for the falling edge, drive back-pressure, observe both DUTs.
  task automatic tick();
    @(negedge clk);
    cyc++;
    drive_wait();
    for (int d = 0; d < 2; d++) monitor(d);
  endtask

  task automatic push_exp(input int d, input int sw, input int sl);
    int len, lat;
    logic [15:0] base;
    wr_t e;
    len  = (d == 0) ? 276 : 4;
    lat  = (d == 0) ? 1 : 3;
    base = (d == 0) ? 16'h0000 : 16'hFFFE;
    for (int k = 0; k < len; k++) begin
      e.dut  = d;
      e.addr = base + 16'(k);
      e.data = (d == 0) ? 8'(k) : (8'(k) ^ 8'hA5);
      e.rel  = (k + 1) * (lat + 1) + ((k >= sw) ? sl : 0);
      e.run  = 1 + ((k == sw) ? sl : 0);
      sq.push_back(e);
    end
  endtask

  task automatic start_copy(input int d);
    logic go, wr, ee, dn;
    logic [15:0] ea, ra, ad;
    logic [7:0] da;
    if (d == 0) start0 = 1'b1; else start1 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
    s_cyc[d] = cyc;
    get_sigs(d, go, wr, ee, dn, ea, ra, ad, da);
    chk("go_after_start", 32'(go), 32'd1);
    chk("done_cleared_by_start", 32'(dn), 32'd0);
    chk("rom_addr_after_start", 32'(ra), 32'd0);
  endtask

  task automatic wait_ee(input int d, input int budget);
    int base;
    int i;
    base = ee_cnt[d];
    i = 0;
    while ((ee_cnt[d] == base) && (i < budget)) begin
      tick();
      i++;
    end
    chk("exec_seen_in_budget", 32'(ee_cnt[d] != base), 32'd1);
  endtask

  task automatic wait_writes(input int d, input int n, input int budget);
    int base;
    int i;
    base = wr_cnt[d];
    i = 0;
    while (((wr_cnt[d] - base) < n) && (i < budget)) begin
      tick();
      i++;
    end
    chk("writes_reached", 32'((wr_cnt[d] - base) >= n), 32'd1);
  endtask

  task automatic check_after_exec(input int d, input int exp_cyc, input logic [15:0] exp_ea);
    logic go, wr, ee, dn;
    logic [15:0] ea, ra, ad;
    logic [7:0] da;
    chk("exec_cycle", ee_rel[d], exp_cyc);
    chk("exec_addr", 32'(ee_addr[d]), 32'(exp_ea));
    chk("done_with_exec", 32'(ee_done[d]), 32'd1);
    chk("go_low_with_exec", 32'(ee_go[d]), 32'd0);
    tick();
    get_sigs(d, go, wr, ee, dn, ea, ra, ad, da);
    chk("exec_one_cycle", 32'(ee), 32'd0);
    chk("exec_addr_cleared", 32'(ea), 32'd0);
    chk("done_sticky", 32'(dn), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int wr_base, ee_base;
    wr_base = wr_cnt[v.dut];
    ee_base = ee_cnt[v.dut];
    push_exp(v.dut, v.sw, v.sl);
    if (v.dut == 0) begin
      stall_addr = 16'(v.sw);
      stall_left = v.sl;
    end else begin
      stall_left = 0;
    end
    start_copy(v.dut);
    wait_ee(v.dut, 2000);
    check_after_exec(v.dut, v.exp_cyc, v.exp_ea);
    for (int i = 0; i < 3; i++) tick();
    chk("exec_pulse_count", ee_cnt[v.dut] - ee_base, 1);
    chk("write_count", wr_cnt[v.dut] - wr_base, v.exp_wr);
    chk("queue_drained", sq.size(), 0);
  endtask

  function automatic logic [31:0] quiet_word(input int d);
    if (d == 0) return 32'({bus0.dn_go, bus0.dn_wr, ee0, done0, bus0.rom_addr});
    else        return 32'({bus1.dn_go, bus1.dn_wr, ee1, done1, bus1.rom_addr});
  endfunction

  initial begin
    logic go, wr, ee, dn;
    logic [15:0] ea, ra, ad;
    logic [7:0] da;
    int ee_base;

    n_chk = 0; n_fail = 0; cyc = 0;
    reset_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    wait0 = 1'b0; wait1 = 1'b0;
    stall_addr = 16'h0000; stall_left = 0;
    for (int d = 0; d < 2; d++) begin
      s_cyc[d] = 0; run[d] = 0; wr_cnt[d] = 0; ee_cnt[d] = 0; ee_rel[d] = 0;
      pa[d] = 16'h0000; pd[d] = 8'h00; ee_addr[d] = 16'h0000;
      ee_done[d] = 1'b0; ee_go[d] = 1'b0;
    end

    vt[0] = '{0, 0,   0, 553, 276, 16'h0000};
    vt[1] = '{0, 10,  5, 558, 276, 16'h0000};
    vt[2] = '{0, 0,   1, 554, 276, 16'h0000};
    vt[3] = '{0, 275, 3, 556, 276, 16'h0000};
    vt[4] = '{1, 0,   0, 17,  4,   16'hBEEF};

    // Reset state, then 100 idle cycles with no start.
    #2;
    for (int d = 0; d < 2; d++) chk("reset_outputs", quiet_word(d), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      for (int d = 0; d < 2; d++) chk("idle_quiet", quiet_word(d), 32'd0);
    end

    // Table of full copies.
    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    // Reset in the middle of word 100, then a clean recopy from word 0.
    stall_left = 0;
    push_exp(0, 0, 0);
    start_copy(0);
    wait_writes(0, 100, 400);
    tick();
    ee_base = ee_cnt[0];
    reset_n = 1'b0;
    #1;
    get_sigs(0, go, wr, ee, dn, ea, ra, ad, da);
    chk("abort_ctrl", 32'({go, wr, ee, dn}), 32'd0);
    chk("abort_rom_addr", 32'(ra), 32'd0);
    chk("abort_dn_addr", 32'(ad), 32'd0);
    chk("abort_dn_data", 32'(da), 32'd0);
    chk("abort_exec_addr", 32'(ea), 32'd0);
    sq.delete();
    for (int i = 0; i < 3; i++) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("no_exec_after_abort", ee_cnt[0] - ee_base, 0);
    chk("idle_after_abort", quiet_word(0), 32'd0);
    run_vec(vt[0]);

    // Start mid-copy and during the execute cycle are ignored; the next cycle's start is taken.
    push_exp(0, 0, 0);
    start_copy(0);
    wait_writes(0, 50, 200);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wait_ee(0, 2000);
    chk("midcopy_start_ignored", ee_rel[0], 553);
    push_exp(0, 0, 0);
    start0 = 1'b1;
    tick();
    get_sigs(0, go, wr, ee, dn, ea, ra, ad, da);
    chk("start_in_exec_ignored", 32'(go), 32'd0);
    chk("done_held_after_exec", 32'(dn), 32'd1);
    tick();
    start0 = 1'b0;
    s_cyc[0] = cyc;
    get_sigs(0, go, wr, ee, dn, ea, ra, ad, da);
    chk("start_after_exec_taken", 32'(go), 32'd1);
    chk("done_cleared_second", 32'(dn), 32'd0);
    wait_ee(0, 2000);
    check_after_exec(0, 553, 16'h0000);
    for (int i = 0; i < 3; i++) tick();
    chk("second_copy_drained", sq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
